// File: rtl/run_control_monitor.sv
// Run controller: start/halt/watchdog sequencing with saturating cycle, retire and trap counters.
// Optional RUN_STATS_EN adds a stall counter and a CPI flag; the default build leaves stall unused.
module run_control_monitor #(
  parameter int unsigned CNT_W          = 32,
  parameter logic [25:0] HALT_CODE      = 26'h300,
  parameter int unsigned DRAIN_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic             trap_valid,
  input  logic [25:0]      trap_code,
  input  logic [31:0]      trap_pc,
  input  logic             stall,
  output logic             running,
  output logic             done,
  output logic             done_pulse,
  output logic             timed_out,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] trap_cnt
`ifdef RUN_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             cpi_flag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  localparam logic             TO_EN      = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [31:0]      DRAIN_LAST = DRAIN_CYCLES - 32'd1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      drain_q, drain_d;
  logic [31:0]      halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;
  logic             timed_out_q, timed_out_d;
  logic             enter_run_s;
  logic             active_s;
  logic             halt_hit_s;
`ifdef RUN_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             cpi_flag_q, cpi_flag_d;
`else
  logic             stall_unused_s;
  assign stall_unused_s = stall;
`endif

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halt_pc_d   = halt_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    trap_cnt_d  = trap_cnt_q;
    enter_run_s = 1'b0;
    active_s    = (state_q == S_RUN) || (state_q == S_DRAIN);
    halt_hit_s  = trap_valid && (trap_code == HALT_CODE);

    case (state_q)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_d     = S_RUN;
          enter_run_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // The halt trap outranks a watchdog expiry in the same cycle.
        if (halt_hit_s) begin
          halt_pc_d = trap_pc;
          if (DRAIN_CYCLES == 32'd0) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LAST;
          end
        end else if (TO_EN && (cycle_cnt_q == TO_LAST)) begin
          state_d = S_TIMEOUT;
        end else begin
          state_d = S_RUN;
        end
        if (trap_valid && !halt_hit_s) begin
          trap_cnt_d = sat_inc(trap_cnt_q);
        end else begin
          trap_cnt_d = trap_cnt_q;
        end
      end
      S_DRAIN: begin
        if (drain_q == 32'd0) begin
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (active_s) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (retire_valid) begin
        instr_cnt_d = sat_inc(instr_cnt_q);
      end else begin
        instr_cnt_d = instr_cnt_q;
      end
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end

    if (enter_run_s) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
      trap_cnt_d  = '0;
      halt_pc_d   = 32'd0;
    end else begin
      halt_pc_d = halt_pc_d;
    end

    running_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d       = (state_d == S_HALTED) || (state_d == S_TIMEOUT);
    timed_out_d  = (state_d == S_TIMEOUT);
    done_pulse_d = done_d && !done_q;

`ifdef RUN_STATS_EN
    stall_cnt_d = stall_cnt_q;
    if (enter_run_s) begin
      stall_cnt_d = '0;
    end else if (active_s && stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    cpi_flag_d = ({1'b0, cycle_cnt_d} > {instr_cnt_d, 1'b0});
`endif
  end

  // State, counters and outputs; reset returns everything to zero without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      drain_q      <= 32'd0;
      halt_pc_q    <= 32'd0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      trap_cnt_q   <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      timed_out_q  <= 1'b0;
`ifdef RUN_STATS_EN
      stall_cnt_q  <= '0;
      cpi_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      halt_pc_q    <= halt_pc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      trap_cnt_q   <= trap_cnt_d;
      running_q    <= running_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      timed_out_q  <= timed_out_d;
`ifdef RUN_STATS_EN
      stall_cnt_q  <= stall_cnt_d;
      cpi_flag_q   <= cpi_flag_d;
`endif
    end
  end

  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign timed_out  = timed_out_q;
  assign halt_pc    = halt_pc_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign trap_cnt   = trap_cnt_q;
`ifdef RUN_STATS_EN
  assign stall_cnt  = stall_cnt_q;
  assign cpi_flag   = cpi_flag_q;
`endif

endmodule

// File: tb/tb_run_control_monitor.sv
// Directed bench for run_control_monitor: a vector table on a 32-bit/watchdog-20 instance,
// plus hand sequences on a 4-bit, zero-drain, no-watchdog instance for saturation and reset abort.
module tb_run_control_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CNT_W=32, DRAIN_CYCLES=1, TIMEOUT_CYCLES=20
  logic        a_rst_n, a_start, a_retire, a_tv, a_stall;
  logic [25:0] a_tcode;
  logic [31:0] a_tpc;
  logic        a_running, a_done, a_pulse, a_tout;
  logic [31:0] a_hpc, a_cyc, a_ins, a_trp;

  // Instance B: CNT_W=4, DRAIN_CYCLES=0, watchdog disabled
  logic        b_rst_n, b_start, b_retire, b_tv, b_stall;
  logic [25:0] b_tcode;
  logic [31:0] b_tpc;
  logic        b_running, b_done, b_pulse, b_tout;
  logic [31:0] b_hpc;
  logic [3:0]  b_cyc, b_ins, b_trp;

`ifdef RUN_STATS_EN
  logic [31:0] a_stall_cnt;
  logic        a_cpi;
  logic [3:0]  b_stall_cnt;
  logic        b_cpi;
`endif

  run_control_monitor #(.CNT_W(32), .HALT_CODE(26'h300), .DRAIN_CYCLES(1), .TIMEOUT_CYCLES(20)) dut_a (
    .clk(clk), .reset(a_rst_n), .start(a_start), .retire_valid(a_retire),
    .trap_valid(a_tv), .trap_code(a_tcode), .trap_pc(a_tpc), .stall(a_stall),
    .running(a_running), .done(a_done), .done_pulse(a_pulse), .timed_out(a_tout),
    .halt_pc(a_hpc), .cycle_cnt(a_cyc), .instr_cnt(a_ins), .trap_cnt(a_trp)
`ifdef RUN_STATS_EN
    , .stall_cnt(a_stall_cnt), .cpi_flag(a_cpi)
`endif
  );

  run_control_monitor #(.CNT_W(4), .HALT_CODE(26'h300), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(b_rst_n), .start(b_start), .retire_valid(b_retire),
    .trap_valid(b_tv), .trap_code(b_tcode), .trap_pc(b_tpc), .stall(b_stall),
    .running(b_running), .done(b_done), .done_pulse(b_pulse), .timed_out(b_tout),
    .halt_pc(b_hpc), .cycle_cnt(b_cyc), .instr_cnt(b_ins), .trap_cnt(b_trp)
`ifdef RUN_STATS_EN
    , .stall_cnt(b_stall_cnt), .cpi_flag(b_cpi)
`endif
  );

  typedef struct {
    logic        start;
    logic        retire;
    logic        tv;
    logic [25:0] tcode;
    logic [31:0] tpc;
    int          n;
    logic        run;
    logic        dn;
    logic        pls;
    logic        to;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] trp;
    logic [31:0] hpc;
  } vec_t;

  vec_t vt[21];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Test 1: halt at RUN cycle 10, one drain cycle
    vt[0]  = '{1'b1, 1'b1, 1'b0, 26'h0,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 26'h0,   32'h0,  10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10, 32'd10, 32'd0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 26'h300, 32'h40, 1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd11, 32'd11, 32'd0, 32'h40};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 26'h0,   32'h0,  1,  1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 32'd12, 32'd0, 32'h40};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 26'h0,   32'h0,  1,  1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 32'd12, 32'd0, 32'h40};
    // Test 3: non-halting traps, ignored start in RUN, trap ignored in DRAIN
    vt[5]  = '{1'b1, 1'b0, 1'b0, 26'h0,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0, 32'h0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  3,  1'b1, 1'b0, 1'b0, 1'b0, 32'd3,  32'd0,  32'd0, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 26'h1,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd4,  32'd0,  32'd1, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 26'h0,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd5,  32'd0,  32'd1, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 26'h1,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd6,  32'd0,  32'd2, 32'h0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  2,  1'b1, 1'b0, 1'b0, 1'b0, 32'd8,  32'd0,  32'd2, 32'h0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 26'h300, 32'h80, 1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd9,  32'd0,  32'd2, 32'h80};
    vt[12] = '{1'b0, 1'b0, 1'b1, 26'h1,   32'h0,  1,  1'b0, 1'b1, 1'b1, 1'b0, 32'd10, 32'd0,  32'd2, 32'h80};
    // Test 2: watchdog after 20 RUN cycles
    vt[13] = '{1'b1, 1'b0, 1'b0, 26'h0,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0, 32'h0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  19, 1'b1, 1'b0, 1'b0, 1'b0, 32'd19, 32'd0,  32'd0, 32'h0};
    vt[15] = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  1,  1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 32'd0,  32'd0, 32'h0};
    vt[16] = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  3,  1'b0, 1'b1, 1'b0, 1'b1, 32'd20, 32'd0,  32'd0, 32'h0};
    // Test 4: halt trap in the watchdog expiry cycle wins
    vt[17] = '{1'b1, 1'b1, 1'b0, 26'h0,   32'h0,  1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0, 32'h0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 26'h0,   32'h0,  19, 1'b1, 1'b0, 1'b0, 1'b0, 32'd19, 32'd19, 32'd0, 32'h0};
    vt[19] = '{1'b0, 1'b1, 1'b1, 26'h300, 32'hC0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 32'd20, 32'd20, 32'd0, 32'hC0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 26'h0,   32'h0,  1,  1'b0, 1'b1, 1'b1, 1'b0, 32'd21, 32'd20, 32'd0, 32'hC0};

    a_rst_n = 1'b0; a_start = 1'b0; a_retire = 1'b0; a_tv = 1'b0; a_tcode = 26'h0; a_tpc = 32'h0; a_stall = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_retire = 1'b0; b_tv = 1'b0; b_tcode = 26'h0; b_tpc = 32'h0; b_stall = 1'b0;
    tick();
    tick();
    chk("rst_a_running", {31'd0, a_running}, 32'd0);
    chk("rst_a_done",    {31'd0, a_done},    32'd0);
    chk("rst_a_pulse",   {31'd0, a_pulse},   32'd0);
    chk("rst_a_tout",    {31'd0, a_tout},    32'd0);
    chk("rst_a_cyc",     a_cyc,              32'd0);
    chk("rst_a_hpc",     a_hpc,              32'd0);
    chk("rst_b_ins",     {28'd0, b_ins},     32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    chk("idle_a_running", {31'd0, a_running}, 32'd0);

    for (int i = 0; i < 21; i++) begin
      a_start  = vt[i].start;
      a_retire = vt[i].retire;
      a_tv     = vt[i].tv;
      a_tcode  = vt[i].tcode;
      a_tpc    = vt[i].tpc;
      repeat (vt[i].n) tick();
      chk($sformatf("v%0d_running", i), {31'd0, a_running}, {31'd0, vt[i].run});
      chk($sformatf("v%0d_done", i),    {31'd0, a_done},    {31'd0, vt[i].dn});
      chk($sformatf("v%0d_pulse", i),   {31'd0, a_pulse},   {31'd0, vt[i].pls});
      chk($sformatf("v%0d_tout", i),    {31'd0, a_tout},    {31'd0, vt[i].to});
      chk($sformatf("v%0d_cyc", i),     a_cyc,              vt[i].cyc);
      chk($sformatf("v%0d_ins", i),     a_ins,              vt[i].ins);
      chk($sformatf("v%0d_trp", i),     a_trp,              vt[i].trp);
      chk($sformatf("v%0d_hpc", i),     a_hpc,              vt[i].hpc);
    end
    a_start = 1'b0; a_retire = 1'b0; a_tv = 1'b0; a_tcode = 26'h0; a_tpc = 32'h0;

`ifdef RUN_STATS_EN
    // Stall on 6 of 10 RUN cycles, retire on 4 of them
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a_stall  = (k < 6);
      a_retire = (k >= 6);
      tick();
    end
    a_stall = 1'b0; a_retire = 1'b0;
    chk("stats_stall_cnt", a_stall_cnt, 32'd6);
    chk("stats_instr",     a_ins,       32'd4);
    chk("stats_cpi_flag",  {31'd0, a_cpi}, 32'd1);
`endif

    // Test 5: 4-bit counters saturate at 4'hF
    b_start = 1'b1; b_retire = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (20) tick();
    chk("b_sat_ins",     {28'd0, b_ins},     32'hF);
    chk("b_sat_cyc",     {28'd0, b_cyc},     32'hF);
    chk("b_sat_running", {31'd0, b_running}, 32'd1);
    // Zero drain: done after the accepting edge itself
    b_retire = 1'b0; b_tv = 1'b1; b_tcode = 26'h300; b_tpc = 32'h1234;
    tick();
    b_tv = 1'b0; b_tcode = 26'h0; b_tpc = 32'h0;
    chk("b_halt_done",    {31'd0, b_done},    32'd1);
    chk("b_halt_pulse",   {31'd0, b_pulse},   32'd1);
    chk("b_halt_running", {31'd0, b_running}, 32'd0);
    chk("b_halt_pc",      b_hpc,              32'h1234);
    tick();
    chk("b_pulse_once",   {31'd0, b_pulse},   32'd0);

    // Second run, aborted by reset mid-run
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    repeat (3) tick();
    chk("b_run2_cyc",     {28'd0, b_cyc},     32'd3);
    chk("b_run2_hpc",     b_hpc,              32'h0);
    b_rst_n = 1'b0;
    #1;
    chk("b_abort_running", {31'd0, b_running}, 32'd0);
    chk("b_abort_cyc",     {28'd0, b_cyc},     32'd0);
    chk("b_abort_ins",     {28'd0, b_ins},     32'd0);
    chk("b_abort_done",    {31'd0, b_done},    32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("b_abort_pulse%0d", k), {31'd0, b_pulse}, 32'd0);
    end
    b_rst_n = 1'b1;
    tick();
    chk("b_after_rst_running", {31'd0, b_running}, 32'd0);
    chk("b_after_rst_pulse",   {31'd0, b_pulse},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
